// File: rtl/uart_defs.sv
// Shared UART definitions: FSM encodings and line levels.
// The transmitter and the receiver both use these.
package uart_defs;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic PAR_EVEN   = 1'b0;
  localparam logic PAR_ODD    = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;

endpackage

// File: rtl/uart_parity_calc.sv
// Parity generator: XOR reduction of the payload.
// The result is inverted when odd parity is selected.
module uart_parity_calc
  import uart_defs::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  typ_i,
  output logic                  par_o
);

  assign par_o = (^data_i) ^ (typ_i == PAR_ODD);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first payload, optional parity bit, one stop bit.
// One serial bit per Clk edge. TX_OUT and Busy come directly from flops.
module uart_tx
  import uart_defs::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [DATA_WIDTH-1:0] P_Data,
  input  logic                  Data_Valid,
  input  logic                  Parity_En,
  input  logic                  Parity_Typ,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  uart_state_e           state_q;
  logic                  tx_q;
  logic                  busy_q;
  logic                  par_en_q;
  logic                  par_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [CW-1:0]         cnt_q;
  logic                  accept;
  logic                  par_calc;

  // A frame starts from IDLE, or from the last stop edge so that frames run back to back.
  assign accept = Data_Valid && ((state_q == IDLE) || (state_q == STOP));

  // Parity is taken from the payload on the acceptance edge, when it is latched.
  uart_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_par (
    .data_i (P_Data),
    .typ_i  (Parity_Typ),
    .par_o  (par_calc)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= IDLE;
      tx_q     <= IDLE_LEVEL;
      busy_q   <= 1'b0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      shift_q  <= '0;
      cnt_q    <= '0;
    end else if (accept) begin
      state_q  <= START;
      tx_q     <= START_BIT;
      busy_q   <= 1'b1;
      shift_q  <= P_Data;
      par_en_q <= Parity_En;
      par_q    <= par_calc;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q   <= IDLE_LEVEL;
          busy_q <= 1'b0;
        end
        START: begin
          tx_q    <= shift_q[0];
          shift_q <= shift_q >> 1;
          cnt_q   <= '0;
          state_q <= DATA;
        end
        DATA: begin
          if (cnt_q == LAST) begin
            if (par_en_q) begin
              tx_q    <= par_q;
              state_q <= PARITY;
            end else begin
              tx_q    <= STOP_BIT;
              state_q <= STOP;
            end
          end else begin
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
            cnt_q   <= cnt_q + 1'b1;
          end
        end
        PARITY: begin
          tx_q    <= STOP_BIT;
          state_q <= STOP;
        end
        STOP: begin
          tx_q    <= IDLE_LEVEL;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          tx_q    <= IDLE_LEVEL;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame shape, parity modes, back-to-back frames,
// ignored mid-frame strobes, asynchronous reset and a receiver-side decode.
module tb_uart_tx;

  logic       Clk;
  logic       Rst;
  logic [7:0] P_Data;
  logic       Data_Valid;
  logic       Parity_En;
  logic       Parity_Typ;
  logic       TX_OUT;
  logic       Busy;

  int tests;
  int fails;

  uart_tx #(.DATA_WIDTH(8)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .P_Data     (P_Data),
    .Data_Valid (Data_Valid),
    .Parity_En  (Parity_En),
    .Parity_Typ (Parity_Typ),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Strobe one frame, then sample the line on 20 falling edges; sample c is the bit after edge N+c.
  // The inputs are scrambled right after acceptance so the frame has to come from the latched copies.
  task automatic run_frame(input logic [7:0] d, input logic en, input logic typ,
                           output logic [19:0] line, output int bc);
    @(negedge Clk);
    P_Data = d; Parity_En = en; Parity_Typ = typ; Data_Valid = 1'b1;
    bc = 0;
    line = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge Clk);
      Data_Valid = 1'b0;
      P_Data = ~d; Parity_En = ~en; Parity_Typ = ~typ;
      line[c] = TX_OUT;
      if (Busy) bc++;
    end
  endtask

  task automatic test_reset();
    Rst = 1'b0; Data_Valid = 1'b0; P_Data = 8'h00; Parity_En = 1'b0; Parity_Typ = 1'b0;
    #12;
    tests++;
    if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: TX_OUT=%b Busy=%b, required TX_OUT=1 Busy=0", TX_OUT, Busy);
    end
    @(negedge Clk); Rst = 1'b1;
    repeat (3) @(negedge Clk);
    tests++;
    if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: TX_OUT=%b Busy=%b, required TX_OUT=1 Busy=0", TX_OUT, Busy);
    end
  endtask

  task automatic test_even_parity();
    logic [19:0] line; int bc;
    run_frame(8'hBB, 1'b1, 1'b0, line, bc);
    tests++;
    if (line[11:0] !== 12'hD76) begin
      fails++; $display("FAIL even_frame: line=%h, required d76", line[11:0]);
    end
    tests++;
    if (bc !== 11) begin
      fails++; $display("FAIL even_busy: busy cycles=%0d, required 11", bc);
    end
    tests++;
    if (line[19:12] !== 8'hFF) begin
      fails++; $display("FAIL even_idle: idle samples=%h, required ff", line[19:12]);
    end
  endtask

  task automatic test_odd_and_noparity();
    logic [19:0] line; int bc;
    run_frame(8'hBB, 1'b1, 1'b1, line, bc);
    tests++;
    if (line[11:0] !== 12'hF76) begin
      fails++; $display("FAIL odd_frame: line=%h, required f76", line[11:0]);
    end
    tests++;
    if (bc !== 11) begin
      fails++; $display("FAIL odd_busy: busy cycles=%0d, required 11", bc);
    end
    run_frame(8'hBB, 1'b0, 1'b0, line, bc);
    tests++;
    if (line[11:0] !== 12'hF76) begin
      fails++; $display("FAIL nopar_frame: line=%h, required f76", line[11:0]);
    end
    tests++;
    if (bc !== 10) begin
      fails++; $display("FAIL nopar_busy: busy cycles=%0d, required 10", bc);
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] line; logic [23:0] bz;
    @(negedge Clk);
    P_Data = 8'hBB; Parity_En = 1'b1; Parity_Typ = 1'b0; Data_Valid = 1'b1;
    for (int c = 0; c < 24; c++) begin
      @(negedge Clk);
      Data_Valid = 1'b0;
      line[c] = TX_OUT;
      bz[c] = Busy;
      if (c == 10) begin
        P_Data = 8'h01; Parity_En = 1'b1; Parity_Typ = 1'b0; Data_Valid = 1'b1;
      end
    end
    tests++;
    if (line[10:0] !== 11'h576) begin
      fails++; $display("FAIL b2b_first: line=%h, required 576", line[10:0]);
    end
    tests++;
    if (line[21:11] !== 11'h602) begin
      fails++; $display("FAIL b2b_second: line=%h, required 602", line[21:11]);
    end
    tests++;
    if (bz[22:0] !== 23'h3FFFFF) begin
      fails++; $display("FAIL b2b_busy: busy=%h, required 3fffff", bz[22:0]);
    end
    tests++;
    if (line[23:22] !== 2'b11) begin
      fails++; $display("FAIL b2b_idle: line=%b, required 11", line[23:22]);
    end
  endtask

  task automatic test_ignore_midframe();
    logic [15:0] line; int bc;
    @(negedge Clk);
    P_Data = 8'hBB; Parity_En = 1'b1; Parity_Typ = 1'b0; Data_Valid = 1'b1;
    bc = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge Clk);
      Data_Valid = 1'b0;
      line[c] = TX_OUT;
      if (Busy) bc++;
      if (c == 4 || c == 8 || c == 9) begin
        P_Data = 8'hFF; Data_Valid = 1'b1;
      end
    end
    tests++;
    if (line[11:0] !== 12'hD76) begin
      fails++; $display("FAIL ignore_frame: line=%h, required d76", line[11:0]);
    end
    tests++;
    if (line[15:12] !== 4'hF || bc !== 11) begin
      fails++; $display("FAIL ignore_after: idle=%h busy=%0d, required f and 11", line[15:12], bc);
    end
  endtask

  task automatic test_async_reset();
    logic [19:0] line; int bc;
    @(negedge Clk);
    P_Data = 8'h00; Parity_En = 1'b1; Parity_Typ = 1'b0; Data_Valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge Clk);
      Data_Valid = 1'b0;
    end
    tests++;
    if (TX_OUT !== 1'b0 || Busy !== 1'b1) begin
      fails++; $display("FAIL pre_reset_bit4: TX_OUT=%b Busy=%b, required 0 1", TX_OUT, Busy);
    end
    Rst = 1'b0;
    #1;
    tests++;
    if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
      fails++; $display("FAIL async_abort: TX_OUT=%b Busy=%b, required 1 0", TX_OUT, Busy);
    end
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    run_frame(8'hA5, 1'b1, 1'b0, line, bc);
    tests++;
    if (line[11:0] !== 12'hD4A || bc !== 11) begin
      fails++; $display("FAIL after_reset_a5: line=%h busy=%0d, required d4a and 11", line[11:0], bc);
    end
  endtask

  // Decode the captured line the way the receiver does and report its outputs.
  task automatic test_loopback();
    logic [19:0] line; int bc;
    logic [7:0] rx; logic perr, ferr, stop_b;
    for (int k = 0; k < 3; k++) begin
      logic en, typ;
      en  = (k != 0);
      typ = (k == 2);
      run_frame(8'hBB, en, typ, line, bc);
      rx     = line[8:1];
      stop_b = en ? line[10] : line[9];
      perr   = en && (((^rx) ^ typ) !== line[9]);
      ferr   = (line[0] !== 1'b0) || (stop_b !== 1'b1);
      tests++;
      if (rx !== 8'hBB || perr !== 1'b0 || ferr !== 1'b0) begin
        fails++;
        $display("FAIL loopback_cfg%0d: data=%h perr=%b ferr=%b, required bb 0 0", k, rx, perr, ferr);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_even_parity();
    test_odd_and_noparity();
    test_back_to_back();
    test_ignore_midframe();
    test_async_reset();
    test_loopback();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
